dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmemory`) between the core's load/store path and an external requester (debug/DMA port). It sits between the core's ALU-address/`rs2data`/`dmwen` signals and the memory. It issues at most one memory access per cycle and stalls the core when the core loses arbitration. The external port may lock the memory for bounded bursts; a starvation counter guarantees core progress.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_BURST`, default 4: maximum consecutive locked external grants while the core is waiting (≥1).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `core_req` in 1: core requests a memory access this cycle.
- `core_we` in 1: core access is a write.
- `core_func3` in 3: core access size/sign.
- `core_addr` in ADDR_W: core address.
- `core_wdata` in DATA_W: core write data.
- `core_gnt` out 1: core access performed this cycle.
- `core_stall` out 1: `core_req & ~core_gnt`; freezes the PC and register-file write.
- `core_rdata` out DATA_W: `mem_rdata` passthrough, same cycle.
- `ext_req`, `ext_we`, `ext_lock` in 1: external request, write, and burst-lock.
- `ext_func3` in 3; `ext_addr` in ADDR_W; `ext_wdata` in DATA_W: external access fields.
- `ext_gnt` out 1: external access performed this cycle.
- `ext_rvalid` out 1: registered read-return strobe.
- `ext_rdata` out DATA_W: registered read data.
- `mem_wen` out 1; `mem_func3` out 3; `mem_addr` out ADDR_W; `mem_wdata` out DATA_W: memory request.
- `mem_rdata` in DATA_W: combinational memory read data.

## Operation
- FSM states are `IDLE` and `EXT_LOCK`. Registered state:
  - `last` owner, reset EXT, so the core wins the first contention.
  - `burst_cnt`, width clog2(MAX_BURST+1), reset 0.
  - `ext_rvalid`, `ext_rdata`, both reset 0.
- Grant is combinational from the requests and registered state. At most one of `core_gnt`/`ext_gnt` is high. Both are 0 while `reset` is low.
- **IDLE:**
  - Single requester: that requester is granted.
  - Both requesting: the one not equal to `last` is granted (round-robin).
  - On a grant, `last` updates to the granted owner.
- **IDLE → EXT_LOCK:** taken when `ext_gnt & ext_lock`. `burst_cnt` is set to 1.
- **EXT_LOCK:**
  - Ext keeps the grant while `ext_req & ext_lock`.
  - `burst_cnt` increments per ext grant when `core_req` is high and saturates at MAX_BURST. It does not increment when the core is idle, so bursts are unbounded without contention.
  - When `burst_cnt == MAX_BURST` and `core_req` is high: the core is granted this cycle, the FSM returns to IDLE, `burst_cnt` clears, and `last` becomes CORE.
  - `ext_req` or `ext_lock` deasserted: return to IDLE and clear `burst_cnt`. If `core_req` is high that cycle, the core is granted.
- **Memory mux:** the `mem_*` fields are selected from the granted owner. `mem_wen = granted_we & (core_gnt | ext_gnt)`. With no grant, `mem_wen = 0` and the address/data fields are don't-care (driven from core).
- **Ext read return:** on an ext read grant, `ext_rdata <= mem_rdata` and `ext_rvalid <= 1` for exactly one cycle. Ext writes produce no `ext_rvalid`.
- **Reset mid-operation:** the FSM forces `IDLE`, all counters clear, and an outstanding `ext_rvalid` is dropped. No `mem_wen` is issued while reset is low.

## Timing
- Grant and the memory request are visible in the same cycle as the request. There is no arbitration latency for an uncontended core.
- Writes commit at the rising edge ending the granted cycle.
- Core read: zero latency (`core_rdata` is combinational).
- Ext read: `ext_rvalid`/`ext_rdata` are valid the cycle after `ext_gnt`.
- The ext requester holds its fields stable until `ext_gnt`. `core_stall` holds the core's fields stable because the PC is frozen.
- Worst-case core wait under contention is MAX_BURST cycles. Without a lock it is 1 cycle.

## Structure
- Shared constants include file, used by `control`, `branch`, and `top`:
  - owner encoding (`OWN_CORE`, `OWN_EXT`),
  - FSM state encoding (`ST_IDLE`, `ST_EXT_LOCK`),
  - func3 width.
- One sub-module, `arb_rr2`: a 2-way round-robin pick from `req[1:0]` and `last`, producing a one-hot `gnt`. It is purely combinational.
- `top` change: `core_stall` gates the PC enable and `rfwenable`.

## Test plan
- **Core only.** `core_req=1`, `we=1`, addr 0x10, data 0xDEADBEEF, `ext_req=0` → `core_gnt=1`, `core_stall=0`, `mem_wen=1`. A following core read of 0x10 returns 0xDEADBEEF on `core_rdata` the same cycle.
- **Contention, first after reset.** Both request in cycle 0 → `core_gnt=1`, `ext_gnt=0`, `core_stall=0`. Both request again in cycle 1 → `ext_gnt=1`, `core_stall=1`. Cycle 2 → core granted.
- **Ext read return.** Ext read of 0x20 holding 0x12345678 → `ext_rvalid` is a single-cycle pulse one cycle after `ext_gnt`, with `ext_rdata=0x12345678`.
- **Locked burst with MAX_BURST=4.** `ext_lock=1`, `ext_req=1`, `core_req=1` from cycle 0 → ext granted cycles 0–3, core granted cycle 4 (`core_stall` high cycles 0–3), FSM in IDLE at cycle 5.
- **Locked burst, no contention.** Locked burst for 10 cycles with `core_req=0` → ext granted all 10 cycles, and `burst_cnt` stays at its entry value (1) throughout because the core is idle.
- **Reset mid-burst.** Assert `reset=0` during a locked ext read → `ext_rvalid=0`, `mem_wen=0`, and no grants during reset. After release with both requesting, the core wins.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: owner ids, FSM states and access-size width.
package dmem_arbiter_pkg;

    localparam int unsigned Func3W = 3;

    typedef enum logic {
        OwnCore = 1'b0,
        OwnExt  = 1'b1
    } owner_e;

    typedef enum logic {
        StIdle    = 1'b0,
        StExtLock = 1'b1
    } state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: bit 0 is the core, bit 1 the external port; output is one-hot or zero.
module arb_rr2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // Both asking: whoever did not own the memory last time wins.
            2'b11:   gnt = (last == OwnExt) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core load/store path and an external (debug/DMA) port,
// with bounded external lock bursts so the core always makes progress.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [Func3W-1:0] core_func3,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic              ext_lock,
    input  logic [Func3W-1:0] ext_func3,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,

    output logic              mem_wen,
    output logic [Func3W-1:0] mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    state_e            state_q, state_d;
    owner_e            last_q, last_d;
    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic              ext_rvalid_q;
    logic [DATA_W-1:0] ext_rdata_q;

    logic [1:0] rr_gnt;
    logic       burst_full;

    assign burst_full = (burst_cnt_q == CntMax);

    arb_rr2 u_arb_rr2 (
        .req  ({ext_req, core_req}),
        .last (last_q),
        .gnt  (rr_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_q       <= OwnExt;
            burst_cnt_q  <= '0;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            burst_cnt_q  <= burst_cnt_d;
            ext_rvalid_q <= ext_gnt & ~ext_we;
            if (ext_gnt && !ext_we) begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if (core_gnt) begin
            last_d = OwnCore;
        end else if (ext_gnt) begin
            last_d = OwnExt;
        end
        unique case (state_q)
            StIdle: begin
                if (ext_gnt && ext_lock) begin
                    state_d     = StExtLock;
                    burst_cnt_d = CntW'(1);
                end
            end
            StExtLock: begin
                if (!(ext_req && ext_lock) || core_gnt) begin
                    state_d     = StIdle;
                    burst_cnt_d = '0;
                end else if (core_req && !burst_full) begin
                    // Only time the core actually waits is charged against the burst budget.
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        core_gnt = 1'b0;
        ext_gnt  = 1'b0;
        unique case (state_q)
            StIdle: begin
                core_gnt = rr_gnt[0];
                ext_gnt  = rr_gnt[1];
            end
            StExtLock: begin
                if (ext_req && ext_lock) begin
                    if (burst_full && core_req) begin
                        core_gnt = 1'b1;
                    end else begin
                        ext_gnt = 1'b1;
                    end
                end else if (core_req) begin
                    core_gnt = 1'b1;
                end else begin
                    ext_gnt = ext_req;
                end
            end
            default: begin
                core_gnt = 1'b0;
            end
        endcase
        if (!reset) begin
            core_gnt = 1'b0;
            ext_gnt  = 1'b0;
        end
    end

    assign core_stall = core_req & ~core_gnt;
    assign core_rdata = mem_rdata;
    assign ext_rvalid = ext_rvalid_q;
    assign ext_rdata  = ext_rdata_q;

    // With no grant the address/data lanes simply follow the core.
    assign mem_wen   = ext_gnt ? ext_we : (core_gnt & core_we);
    assign mem_func3 = ext_gnt ? ext_func3 : core_func3;
    assign mem_addr  = ext_gnt ? ext_addr : core_addr;
    assign mem_wdata = ext_gnt ? ext_wdata : core_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic
// compared against a behavioural arbitration and memory model.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned MAX_BURST = 4;

    logic              clk;
    logic              reset;
    logic              core_req, core_we;
    logic [2:0]        core_func3;
    logic [31:0]       core_addr, core_wdata, core_rdata;
    logic              core_gnt, core_stall;
    logic              ext_req, ext_we, ext_lock;
    logic [2:0]        ext_func3;
    logic [31:0]       ext_addr, ext_wdata, ext_rdata;
    logic              ext_gnt, ext_rvalid;
    logic              mem_wen;
    logic [2:0]        mem_func3;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];

    // Reference arbitration state.
    bit m_last_ext;
    bit m_locked;
    int m_budget;

    // DUT outputs sampled in the most recent cycle.
    bit s_cg, s_eg, s_stall;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_func3 (core_func3),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_lock   (ext_lock),
        .ext_func3  (ext_func3),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_gnt    (ext_gnt),
        .ext_rvalid (ext_rvalid),
        .ext_rdata  (ext_rdata),
        .mem_wen    (mem_wen),
        .mem_func3  (mem_func3),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_ext = 1'b1;
        m_locked   = 1'b0;
        m_budget   = 0;
    endtask

    // Arbitration rules: round-robin when free; a lock keeps ext until the core has been
    // charged MAX_BURST ext grants (entry grant counts, later ones only while the core asks).
    task automatic model_step(input bit creq, input bit ereq, input bit elock,
                              output bit gc, output bit ge);
        gc = 1'b0;
        ge = 1'b0;
        if (!m_locked) begin
            if (creq && ereq) begin
                gc = m_last_ext;
                ge = !m_last_ext;
            end else begin
                gc = creq;
                ge = ereq;
            end
            if (ge && elock) begin
                m_locked = 1'b1;
                m_budget = 1;
            end
        end else if (ereq && elock) begin
            if (creq && m_budget >= int'(MAX_BURST)) begin
                gc       = 1'b1;
                m_locked = 1'b0;
                m_budget = 0;
            end else begin
                ge = 1'b1;
                if (creq && m_budget < int'(MAX_BURST)) m_budget++;
            end
        end else begin
            m_locked = 1'b0;
            m_budget = 0;
            gc = creq;
            ge = !creq && ereq;
        end
        if (gc) m_last_ext = 1'b0;
        if (ge) m_last_ext = 1'b1;
    endtask

    task automatic do_cycle(input bit creq, input bit cwe, input logic [31:0] caddr,
                            input logic [31:0] cwd, input bit ereq, input bit ewe,
                            input bit elock, input logic [31:0] eaddr, input logic [31:0] ewd);
        bit          gc, ge, exp_wen, pend_rv;
        logic [31:0] pend_data;
        @(negedge clk);
        core_req   = creq;
        core_we    = cwe;
        core_func3 = 3'b010;
        core_addr  = caddr;
        core_wdata = cwd;
        ext_req    = ereq;
        ext_we     = ewe;
        ext_lock   = elock;
        ext_func3  = 3'b010;
        ext_addr   = eaddr;
        ext_wdata  = ewd;
        #1;
        model_step(creq, ereq, elock, gc, ge);
        s_cg    = core_gnt;
        s_eg    = ext_gnt;
        s_stall = core_stall;
        chk("core_gnt", 64'(core_gnt), 64'(gc));
        chk("ext_gnt", 64'(ext_gnt), 64'(ge));
        chk("core_stall", 64'(core_stall), 64'(creq && !gc));
        exp_wen = (gc && cwe) || (ge && ewe);
        chk("mem_wen", 64'(mem_wen), 64'(exp_wen));
        if (gc || ge) chk("mem_addr", 64'(mem_addr), 64'(ge ? eaddr : caddr));
        if (exp_wen) chk("mem_wdata", 64'(mem_wdata), 64'(ge ? ewd : cwd));
        if (gc && !cwe) chk("core_rdata", 64'(core_rdata), 64'(ref_mem[caddr[7:2]]));
        pend_rv   = ge && !ewe;
        pend_data = ref_mem[eaddr[7:2]];
        if (gc && cwe) ref_mem[caddr[7:2]] = cwd;
        if (ge && ewe) ref_mem[eaddr[7:2]] = ewd;
        @(posedge clk);
        #1;
        chk("ext_rvalid", 64'(ext_rvalid), 64'(pend_rv));
        if (pend_rv) chk("ext_rdata", 64'(ext_rdata), 64'(pend_data));
    endtask

    task automatic idle_inputs();
        core_req = 1'b0;
        core_we  = 1'b0;
        ext_req  = 1'b0;
        ext_we   = 1'b0;
        ext_lock = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        core_func3 = 3'b010;
        ext_func3  = 3'b010;
        core_addr  = '0;
        core_wdata = '0;
        ext_addr   = '0;
        ext_wdata  = '0;
        idle_inputs();
        model_reset();

        // Reset: nothing granted or written even with both sides asking to write.
        reset    = 1'b0;
        core_req = 1'b1;
        core_we  = 1'b1;
        ext_req  = 1'b1;
        ext_we   = 1'b1;
        #12;
        chk("rst_core_gnt", 64'(core_gnt), 64'd0);
        chk("rst_ext_gnt", 64'(ext_gnt), 64'd0);
        chk("rst_mem_wen", 64'(mem_wen), 64'd0);
        chk("rst_ext_rvalid", 64'(ext_rvalid), 64'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;

        // First contention after reset: core, then ext, then core.
        do_cycle(1, 0, 32'h40, 0, 1, 0, 0, 32'h44, 0);
        chk("cont0_core", 64'(s_cg), 64'd1);
        chk("cont0_stall", 64'(s_stall), 64'd0);
        do_cycle(1, 0, 32'h40, 0, 1, 0, 0, 32'h44, 0);
        chk("cont1_ext", 64'(s_eg), 64'd1);
        chk("cont1_stall", 64'(s_stall), 64'd1);
        do_cycle(1, 0, 32'h40, 0, 0, 0, 0, 32'h44, 0);
        chk("cont2_core", 64'(s_cg), 64'd1);

        // Core-only write then same-cycle read back.
        do_cycle(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("cw_mem_wen", 64'(s_cg), 64'd1);
        @(negedge clk);
        core_req = 1'b1;
        core_we  = 1'b0;
        core_addr = 32'h10;
        #1;
        chk("cr_rdata", 64'(core_rdata), 64'h0000_0000_DEAD_BEEF);
        do_cycle(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);

        // Ext read return: one-cycle pulse after the grant.
        do_cycle(1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 0, 0, 32'h20, 0);
        chk("er_gnt", 64'(s_eg), 64'd1);
        chk("er_rdata", 64'(ext_rdata), 64'h0000_0000_1234_5678);
        do_cycle(1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
        chk("er_pulse_end", 64'(ext_rvalid), 64'd0);

        // Locked burst against a waiting core (last owner is the core here).
        for (int i = 0; i < 5; i++) begin
            do_cycle(1, 0, 32'h10, 0, 1, 1, 1, 32'h80 + 32'(i * 4), 32'hA000 + 32'(i));
            if (i < 4) begin
                chk("lb_ext_gnt", 64'(s_eg), 64'd1);
                chk("lb_stall", 64'(s_stall), 64'd1);
            end else begin
                chk("lb_core_gnt", 64'(s_cg), 64'd1);
            end
        end
        chk("lb_fsm_idle", 64'(dut.state_q), 64'(StIdle));
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Locked burst with the core idle: unbounded, budget stays at its entry value.
        for (int i = 0; i < 10; i++) begin
            do_cycle(0, 0, 0, 0, 1, 0, 1, 32'h80 + 32'((i % 4) * 4), 0);
            chk("nc_ext_gnt", 64'(s_eg), 64'd1);
            chk("nc_burst_cnt", 64'(dut.burst_cnt_q), 64'd1);
        end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit creq, cwe, ereq, ewe, elock;
            creq  = 1'($urandom_range(0, 1));
            cwe   = 1'($urandom_range(0, 1));
            ereq  = ($urandom_range(0, 3) != 0);
            ewe   = 1'($urandom_range(0, 1));
            elock = ereq && ($urandom_range(0, 2) != 0);
            do_cycle(creq, cwe, 32'($urandom_range(0, 63)) << 2, $urandom,
                     ereq, ewe, elock, 32'($urandom_range(0, 63)) << 2, $urandom);
        end
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while a locked ext read return is outstanding.
        do_cycle(0, 0, 0, 0, 1, 0, 1, 32'h10, 0);
        do_cycle(0, 0, 0, 0, 1, 0, 1, 32'h20, 0);
        core_req = 1'b1;
        core_we  = 1'b1;
        reset    = 1'b0;
        #1;
        chk("mr_ext_rvalid", 64'(ext_rvalid), 64'd0);
        chk("mr_core_gnt", 64'(core_gnt), 64'd0);
        chk("mr_ext_gnt", 64'(ext_gnt), 64'd0);
        chk("mr_mem_wen", 64'(mem_wen), 64'd0);
        chk("mr_fsm_idle", 64'(dut.state_q), 64'(StIdle));
        @(negedge clk);
        chk("mr_hold_wen", 64'(mem_wen), 64'd0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        do_cycle(1, 0, 32'h10, 0, 1, 0, 1, 32'h20, 0);
        chk("mr_core_wins", 64'(s_cg), 64'd1);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
